fifo_ctrl: RTL and testbench
============================

// Module: fifo_ctrl
// PURPOSE
//  Pointer/flag controller placed directly upstream of the dual-port RAM in the PCIe buffer path.
//  Converts a push/pop client interface into the RAM's wr_enb/wr_addr/data_in and rd_enb/rd_addr
//  controls, and returns RAM data_out as pop_data with a valid strobe.
//  Tracks occupancy, full/empty and almost flags, plus sticky overflow/underflow errors.
// PARAMETERS
//  RAM_WIDTH  10  data word width; equals the RAM word width
//  RAM_DEPTH  8   number of RAM entries; must equal 2**ADDR_SIZE
//  ADDR_SIZE  3   RAM address width
//  AF_THRESH  6   almost_full asserts when count >= AF_THRESH
//  AE_THRESH  2   almost_empty asserts when count <= AE_THRESH
// PORTS
//  clk            in   1            single clock; all state updates on posedge
//  rst            in   1            asynchronous, active-low reset
//  push           in   1            client write request
//  push_data      in   RAM_WIDTH    word to write
//  pop            in   1            client read request
//  pop_data       out  RAM_WIDTH    read word; equals data_out; meaningful only while pop_valid=1
//  pop_valid      out  1            pop_data valid, one cycle after an accepted pop
//  full           out  1            count == RAM_DEPTH
//  empty          out  1            count == 0
//  almost_full    out  1            count >= AF_THRESH
//  almost_empty   out  1            count <= AE_THRESH
//  count          out  ADDR_SIZE+1  current occupancy, 0..RAM_DEPTH
//  err_overflow   out  1            sticky: push seen while full
//  err_underflow  out  1            sticky: pop seen while empty
//  wr_enb         out  1            RAM write enable
//  wr_addr        out  ADDR_SIZE    RAM write address
//  data_in        out  RAM_WIDTH    RAM write data
//  rd_enb         out  1            RAM read enable
//  rd_addr        out  ADDR_SIZE    RAM read address
//  data_out       in   RAM_WIDTH    RAM read data, registered by the RAM one cycle after rd_enb
// BEHAVIOUR
//  Reset (rst=0, async):
//   - wr_ptr=0, rd_ptr=0, count=0, pop_valid=0, err_*=0.
//   - empty=1, full=0, almost_empty=1, almost_full=0.
//   - wr_enb=0 and rd_enb=0 forced while rst=0; RAM contents are not cleared.
//  Write acceptance:
//   - push_ok = push & ~full.
//   - Memory-side outputs are combinational: wr_enb=push_ok, wr_addr=wr_ptr, data_in=push_data.
//   - The RAM writes on the same edge; wr_ptr increments on that edge.
//  Read acceptance:
//   - pop_ok = pop & ~empty.
//   - Combinational: rd_enb=pop_ok, rd_addr=rd_ptr; rd_ptr increments on that edge.
//   - pop_valid is a register loaded with pop_ok, so it is high exactly the cycle after an accepted pop.
//   - pop_data = data_out (passthrough). Read latency is 1 cycle.
//  Gating uses the current-cycle flags only:
//   - push while full is rejected even if a pop is accepted in the same cycle.
//   - pop while empty is rejected even if a push is accepted in the same cycle.
//  Count update per edge:
//   - +1 on push_ok only; -1 on pop_ok only; unchanged when both or neither are accepted.
//  Flags are decoded combinationally from the count register.
//  Pointers are ADDR_SIZE bits and wrap naturally from RAM_DEPTH-1 to 0.
//  Errors:
//   - err_overflow sets on an edge with push & full; err_underflow sets on an edge with pop & empty.
//   - Both clear only on reset. A rejected request changes no pointer or count.
//  Reset asserted mid-operation immediately clears all state. A pop_valid pending from the
//   previous cycle is dropped.
//  Back-to-back:
//   - Push on cycle N and pop on cycle N+1 to the same entry is legal; the RAM was written at edge N.
//   - Sustained push+pop at one word per cycle holds count constant.
// TESTING
//  1. Reset then idle -> empty=1, count=0, wr_enb=rd_enb=0, err_*=0.
//  2. Push 0x0FF, 0x0CC, 0x3A5 -> wr_addr 0,1,2; count=3. Then pop x3 -> pop_valid on the next
//     cycle each, pop_data 0x0FF, 0x0CC, 0x3A5 in order; empty=1.
//  3. Push 8 words 0x001..0x008 -> full=1, almost_full from count 6. A 9th push -> err_overflow=1,
//     wr_enb=0, count stays 8.
//  4. Pop when empty -> rd_enb=0, pop_valid stays 0, err_underflow=1. It stays set until rst=0.
//  5. Steady state: count=4, push+pop every cycle for 12 cycles -> count constant at 4; pointers wrap
//     7->0; data in order.
//  6. Count=5, assert rst=0 between edges -> count=0, empty=1, pop_valid=0 immediately. After release,
//     a push lands at wr_addr=0.

Source files
------------

// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: the client push/pop bus and the dual-port RAM control bus of
// fifo_ctrl, bundled into one interface.
//   master : the environment side (client plus RAM). It drives push, push_data,
//            pop and the RAM read data data_out, and it observes everything else.
//   slave  : the controller side (fifo_ctrl).
// Signals:
//   push, push_data, pop        client requests
//   pop_data, pop_valid         read return, one cycle after an accepted pop
//   count, full, empty,
//   almost_full, almost_empty   occupancy and the flags decoded from it
//   err_overflow, err_underflow sticky error flags
//   wr_enb, wr_addr, data_in    RAM write port controls
//   rd_enb, rd_addr, data_out   RAM read port controls and registered read data
interface fifo_ctrl_if #(
    parameter int RAM_WIDTH = 10,
    parameter int ADDR_SIZE = 3
);
    logic                 push;
    logic [RAM_WIDTH-1:0] push_data;
    logic                 pop;
    logic [RAM_WIDTH-1:0] pop_data;
    logic                 pop_valid;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [ADDR_SIZE:0]   count;
    logic                 err_overflow;
    logic                 err_underflow;
    logic                 wr_enb;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [RAM_WIDTH-1:0] data_in;
    logic                 rd_enb;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [RAM_WIDTH-1:0] data_out;

    modport master (
        output push, push_data, pop, data_out,
        input  pop_data, pop_valid, full, empty, almost_full, almost_empty,
               count, err_overflow, err_underflow,
               wr_enb, wr_addr, data_in, rd_enb, rd_addr
    );

    modport slave (
        input  push, push_data, pop, data_out,
        output pop_data, pop_valid, full, empty, almost_full, almost_empty,
               count, err_overflow, err_underflow,
               wr_enb, wr_addr, data_in, rd_enb, rd_addr
    );
endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: the pointer and flag controller that sits directly in front of a
// dual-port RAM in the PCIe buffer path. It turns client push/pop requests into
// RAM write and read controls, and it passes the registered RAM read data back
// as pop_data together with a one-cycle pop_valid strobe.
// Ports:
//   clk  single clock; all state changes on the rising edge
//   rst  asynchronous, active-low reset
//   bus  fifo_ctrl_if.slave, which carries the client bus, the flags, the errors
//        and the RAM controls
module fifo_ctrl #(
    parameter int RAM_WIDTH = 10,
    parameter int RAM_DEPTH = 8,
    parameter int ADDR_SIZE = 3,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fifo_ctrl_if.slave   bus
);
    localparam int CW = ADDR_SIZE + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RAM_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [ADDR_SIZE-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]        cnt;
    logic                 pop_vld_q;
    logic                 err_ov_q, err_un_q;
    logic                 full_w, empty_w;
    logic                 push_ok, pop_ok;

    // Acceptance looks only at this cycle's flags. A push while full is
    // rejected even when a pop in the same cycle would free a slot, and the
    // same holds for a pop while empty.
    assign full_w  = (cnt == DEPTH_C);
    assign empty_w = (cnt == '0);
    assign push_ok = bus.push & ~full_w;
    assign pop_ok  = bus.pop  & ~empty_w;

    // RAM controls are combinational, so the RAM acts on the same edge that
    // moves the pointers. Both enables are held low while reset is asserted,
    // so the RAM contents are left untouched.
    assign bus.wr_enb  = push_ok & rst;
    assign bus.wr_addr = wr_ptr;
    assign bus.data_in = bus.push_data;
    assign bus.rd_enb  = pop_ok & rst;
    assign bus.rd_addr = rd_ptr;

    // The RAM registers its read data, so data_out lines up with pop_vld_q.
    assign bus.pop_data      = bus.data_out;
    assign bus.pop_valid     = pop_vld_q;
    assign bus.count         = cnt;
    assign bus.full          = full_w;
    assign bus.empty         = empty_w;
    assign bus.almost_full   = (cnt >= AF_C);
    assign bus.almost_empty  = (cnt <= AE_C);
    assign bus.err_overflow  = err_ov_q;
    assign bus.err_underflow = err_un_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            pop_vld_q <= 1'b0;
            err_ov_q  <= 1'b0;
            err_un_q  <= 1'b0;
        end else begin
            // The pointers are exactly ADDR_SIZE bits wide, so they wrap on their own.
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            pop_vld_q <= pop_ok;
            if (bus.push && full_w)  err_ov_q <= 1'b1;
            if (bus.pop  && empty_w) err_un_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;
    localparam int W = 10;
    localparam int A = 3;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_ctrl_if #(.RAM_WIDTH(W), .ADDR_SIZE(A)) bus ();

    fifo_ctrl #(
        .RAM_WIDTH(W), .RAM_DEPTH(D), .ADDR_SIZE(A), .AF_THRESH(6), .AE_THRESH(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural dual-port RAM with registered read data.
    logic [W-1:0] mem [D];
    logic [W-1:0] ram_q = '0;
    always @(posedge clk) begin
        if (bus.wr_enb) mem[bus.wr_addr] <= bus.data_in;
        if (bus.rd_enb) ram_q <= mem[bus.rd_addr];
    end
    assign bus.data_out = ram_q;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] fifo_m[$];
    logic [W-1:0] exp_q[$];
    logic [A-1:0] exp_wr, exp_rd;
    logic [W-1:0] mon_exp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: compares every pop_valid beat with the oldest expected word.
    always @(negedge clk) begin
        if (bus.pop_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_valid_spurious: got 1 expected 0");
            end else begin
                mon_exp = exp_q.pop_front();
                chk("pop_data", 32'(bus.pop_data), 32'(mon_exp));
            end
        end
    end

    task automatic chk_flags(input int c);
        chk("count", 32'(bus.count), 32'(c));
        chk("empty", 32'(bus.empty), 32'(c == 0));
        chk("full", 32'(bus.full), 32'(c == D));
        chk("almost_full", 32'(bus.almost_full), 32'(c >= 6));
        chk("almost_empty", 32'(bus.almost_empty), 32'(c <= 2));
    endtask

    // One clock of stimulus. It also checks the combinational RAM controls and
    // the occupancy after the edge.
    task automatic cyc(input logic p, input logic [W-1:0] d, input logic q,
                       input logic pok, input logic qok, input int cnt_after);
        @(negedge clk);
        #1;
        chk("pop_valid_missing", 32'(exp_q.size()), 32'd0);
        bus.push = p;
        bus.push_data = d;
        bus.pop = q;
        #1;
        chk("wr_enb", 32'(bus.wr_enb), 32'(pok));
        if (pok) begin
            chk("wr_addr", 32'(bus.wr_addr), 32'(exp_wr));
            chk("data_in", 32'(bus.data_in), 32'(d));
        end
        chk("rd_enb", 32'(bus.rd_enb), 32'(qok));
        if (qok) chk("rd_addr", 32'(bus.rd_addr), 32'(exp_rd));
        @(posedge clk);
        if (pok) begin
            fifo_m.push_back(d);
            exp_wr = exp_wr + 1'b1;
        end
        if (qok) begin
            exp_q.push_back(fifo_m.pop_front());
            exp_rd = exp_rd + 1'b1;
        end
        #1;
        chk_flags(cnt_after);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.push = 1'b1;
        bus.push_data = '0;
        bus.pop = 1'b1;
        exp_wr = '0;
        exp_rd = '0;
        // Reset: the enables must stay low even though push is requested.
        #3;
        chk("rst_wr_enb", 32'(bus.wr_enb), 32'd0);
        chk("rst_rd_enb", 32'(bus.rd_enb), 32'd0);
        chk("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
        chk("rst_err_ov", 32'(bus.err_overflow), 32'd0);
        chk("rst_err_un", 32'(bus.err_underflow), 32'd0);
        chk_flags(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.push = 1'b0;
        bus.pop = 1'b0;
        rst = 1'b1;

        // 1: idle
        cyc(0, '0, 0, 0, 0, 0);
        chk("idle_err_ov", 32'(bus.err_overflow), 32'd0);

        // 2: three pushes, then three pops in order
        cyc(1, 10'h0FF, 0, 1, 0, 1);
        cyc(1, 10'h0CC, 0, 1, 0, 2);
        cyc(1, 10'h3A5, 0, 1, 0, 3);
        cyc(0, '0, 1, 0, 1, 2);
        cyc(0, '0, 1, 0, 1, 1);
        cyc(0, '0, 1, 0, 1, 0);
        cyc(0, '0, 0, 0, 0, 0);

        // 3: fill to full, push into a full FIFO, then push+pop while full
        for (int i = 0; i < 8; i++) cyc(1, W'(i + 1), 0, 1, 0, i + 1);
        cyc(1, 10'h009, 0, 0, 0, 8);
        chk("err_overflow", 32'(bus.err_overflow), 32'd1);
        chk("err_underflow_clean", 32'(bus.err_underflow), 32'd0);
        cyc(1, 10'h00A, 1, 0, 1, 7);
        for (int i = 0; i < 7; i++) cyc(0, '0, 1, 0, 1, 6 - i);
        cyc(0, '0, 0, 0, 0, 0);

        // 4: pop while empty, then push+pop while empty
        cyc(0, '0, 1, 0, 0, 0);
        chk("err_underflow", 32'(bus.err_underflow), 32'd1);
        cyc(0, '0, 0, 0, 0, 0);
        cyc(1, 10'h055, 1, 1, 0, 1);
        chk("err_underflow_sticky", 32'(bus.err_underflow), 32'd1);

        // 5: bring count to 4, then 12 cycles at full rate (both pointers wrap)
        cyc(1, 10'h056, 0, 1, 0, 2);
        cyc(1, 10'h057, 0, 1, 0, 3);
        cyc(1, 10'h058, 0, 1, 0, 4);
        for (int i = 0; i < 12; i++) cyc(1, W'(10'h100 + i), 1, 1, 1, 4);

        // 6: reset asserted between edges while a pop_valid is pending
        cyc(1, 10'h1F0, 0, 1, 0, 5);
        cyc(1, 10'h1F1, 0, 1, 0, 6);
        cyc(0, '0, 1, 0, 1, 5);
        chk("pending_pop_valid", 32'(bus.pop_valid), 32'd1);
        chk("err_ov_sticky", 32'(bus.err_overflow), 32'd1);
        #1;
        bus.push = 1'b1;
        rst = 1'b0;
        exp_q.delete();
        fifo_m.delete();
        exp_wr = '0;
        exp_rd = '0;
        #1;
        chk("midrst_pop_valid", 32'(bus.pop_valid), 32'd0);
        chk("midrst_wr_enb", 32'(bus.wr_enb), 32'd0);
        chk("midrst_err_ov", 32'(bus.err_overflow), 32'd0);
        chk("midrst_err_un", 32'(bus.err_underflow), 32'd0);
        chk_flags(0);
        @(negedge clk);
        bus.push = 1'b0;
        rst = 1'b1;
        cyc(1, 10'h2AA, 0, 1, 0, 1);
        cyc(0, '0, 1, 0, 1, 0);
        cyc(0, '0, 0, 0, 0, 0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
